// File: rtl/dcm_seq_pkg.sv
// -----------------------------------------------------------------------------
// dcm_seq_pkg
// Shared definitions for the DCM lock sequencer:
//   - state_t     : FSM state encoding (also driven out on STATE for debug)
//   - STAT_*      : bit indices inside the DCM STATUS buses
//   - max2        : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package dcm_seq_pkg;

  typedef enum logic [2:0] {
    S_RST1   = 3'd0,
    S_WAIT1  = 3'd1,
    S_RST2   = 3'd2,
    S_WAIT2  = 3'd3,
    S_RUN    = 3'd4,
    S_FAILED = 3'd5
  } state_t;

  localparam int STAT_CLKIN_STOP = 1;  // DCM1 STATUS: CLKIN stopped
  localparam int STAT_CLKFX_STOP = 2;  // DCM2 STATUS: CLKFX stopped

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Parameterised-width two-flop synchronizer. Each bit is synchronized
// independently; no multi-bit coherency is implied.
// Ports:
//   clk : destination clock
//   d   : asynchronous inputs [W-1:0]
//   q   : synchronized outputs [W-1:0], two clk edges behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/dcm_lock_sequencer.sv
// -----------------------------------------------------------------------------
// dcm_lock_sequencer
// Brings up the cascaded DCM pair of the MIO clock generator (DCM1 then DCM2),
// monitors lock / clock-stopped status, restarts the affected stage on loss
// and flags permanent failure once the retry budget is exhausted.
// Ports (all on BUS_CLK rising edge):
//   BUS_CLK, BUS_RST    : clock, synchronous active-high reset
//   USER_RST            : 1-cycle pulse, full restart from DCM1, clears FAIL/RETRY_CNT
//   DCM1_LOCKED/STATUS  : DCM1 status (async), STATUS bit1 = CLKIN stopped
//   DCM2_LOCKED/STATUS  : DCM2 status (async), STATUS bit2 = CLKFX stopped
//   DCM1_RST, DCM2_RST  : DCM reset drives
//   CLK_READY           : both stages locked and stable
//   FAIL                : sticky, retries exhausted
//   STATE               : current state encoding (debug)
//   RETRY_CNT           : failed attempts since last RUN entry
//   LOSS_CNT            : lock losses seen in RUN, saturating, cleared by BUS_RST only
// -----------------------------------------------------------------------------
module dcm_lock_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int MAX_RETRY     = 3
) (
  input  logic                             BUS_CLK,
  input  logic                             BUS_RST,
  input  logic                             USER_RST,
  input  logic                             DCM1_LOCKED,
  input  logic [7:0]                       DCM1_STATUS,
  input  logic                             DCM2_LOCKED,
  input  logic [7:0]                       DCM2_STATUS,
  output logic                             DCM1_RST,
  output logic                             DCM2_RST,
  output logic                             CLK_READY,
  output logic                             FAIL,
  output logic [2:0]                       STATE,
  output logic [$clog2(MAX_RETRY+1)-1:0]   RETRY_CNT,
  output logic [7:0]                       LOSS_CNT
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int CW = $clog2(max2(RST_CYCLES, STABLE_CYCLES) + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW:0]   RETRY_LIM = (RW+1)'(MAX_RETRY);

  // Status bits other than the two stop flags are intentionally ignored.
  logic unused_status;
  assign unused_status = ^{DCM1_STATUS, DCM2_STATUS};

  // Synchronizer stage: {stop2, lock2, stop1, lock1}
  logic [3:0] async_in;
  logic [3:0] synced;

  assign async_in = {DCM2_STATUS[STAT_CLKFX_STOP], DCM2_LOCKED,
                     DCM1_STATUS[STAT_CLKIN_STOP], DCM1_LOCKED};

  sync_2ff #(.W(4)) u_sync (
    .clk (BUS_CLK),
    .d   (async_in),
    .q   (synced)
  );

  logic lock1, stop1, lock2, stop2;
  logic fault1, fault2;

  assign lock1  = synced[0];
  assign stop1  = synced[1];
  assign lock2  = synced[2];
  assign stop2  = synced[3];
  assign fault1 = ~lock1 | stop1;
  assign fault2 = ~lock2 | stop2;

  // FSM state and shared counters
  state_t        state, nxt;
  logic [CW-1:0] cnt;        // reset length in RSTx, stability run in WAITx
  logic [TW-1:0] tmo;        // cycles spent in the current WAITx
  logic          retry_ev;
  logic          loss_ev;
  logic [RW:0]   retry_sum;  // one bit wider so MAX_RETRY+1 is representable

  assign STATE = state;

  always_comb begin
    nxt       = state;
    retry_ev  = 1'b0;
    loss_ev   = 1'b0;
    retry_sum = {1'b0, RETRY_CNT} + (RW+1)'(1);

    unique case (state)
      S_RST1: begin
        if (cnt == RST_LAST) nxt = S_WAIT1;
      end
      S_WAIT1: begin
        if (tmo == TMO_LAST)               retry_ev = 1'b1;
        else if (lock1 && cnt == STB_LAST) nxt = S_RST2;
      end
      S_RST2: begin
        if (cnt == RST_LAST) nxt = S_WAIT2;
      end
      S_WAIT2: begin
        // Losing DCM1 while waiting on DCM2 restarts the chain without
        // charging a retry.
        if (fault1)                        nxt = S_RST1;
        else if (tmo == TMO_LAST)          retry_ev = 1'b1;
        else if (lock2 && cnt == STB_LAST) nxt = S_RUN;
      end
      S_RUN: begin
        if (fault1) begin
          nxt     = S_RST1;
          loss_ev = 1'b1;
        end else if (fault2) begin
          nxt     = S_RST2;
          loss_ev = 1'b1;
        end
      end
      S_FAILED: nxt = S_FAILED;
      default:  nxt = S_RST1;
    endcase

    if (retry_ev)
      nxt = (retry_sum > RETRY_LIM) ? S_FAILED
          : ((state == S_WAIT1) ? S_RST1 : S_RST2);

    if (USER_RST) nxt = S_RST1;
  end

  // Registered outputs are decoded from the next state so they change on
  // the same edge as the state register; CLK_READY cannot lag a RUN exit.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= S_RST1;
      cnt       <= '0;
      tmo       <= '0;
      RETRY_CNT <= '0;
      LOSS_CNT  <= '0;
      DCM1_RST  <= 1'b1;
      DCM2_RST  <= 1'b1;
      CLK_READY <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      state     <= nxt;
      DCM1_RST  <= (nxt == S_RST1) || (nxt == S_FAILED);
      DCM2_RST  <= (nxt != S_WAIT2) && (nxt != S_RUN);
      CLK_READY <= (nxt == S_RUN);
      FAIL      <= (nxt == S_FAILED);

      if (USER_RST || nxt != state) begin
        cnt <= '0;
        tmo <= '0;
      end else begin
        unique case (state)
          S_RST1, S_RST2: cnt <= cnt + CW'(1);
          S_WAIT1:        cnt <= lock1 ? cnt + CW'(1) : '0;
          S_WAIT2:        cnt <= lock2 ? cnt + CW'(1) : '0;
          default:        cnt <= cnt;
        endcase
        if ((state == S_WAIT1 || state == S_WAIT2) && tmo != '1)
          tmo <= tmo + TW'(1);
      end

      // The attempt that exhausts the budget leaves RETRY_CNT at MAX_RETRY;
      // FAIL carries the information from then on.
      if (USER_RST)
        RETRY_CNT <= '0;
      else if (nxt == S_RUN && state != S_RUN)
        RETRY_CNT <= '0;
      else if (retry_ev && retry_sum <= RETRY_LIM)
        RETRY_CNT <= retry_sum[RW-1:0];

      if (loss_ev && !USER_RST && LOSS_CNT != 8'hFF)
        LOSS_CNT <= LOSS_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dcm_lock_sequencer
// Directed bench for dcm_lock_sequencer with small timing parameters.
// Expected output vectors are queued when stimulus is applied and popped
// when the DUT is sampled; timing checks compare the cycle of each event
// against the cycle derived from the stimulus schedule.
// -----------------------------------------------------------------------------
module tb_dcm_lock_sequencer;

  logic       BUS_CLK;
  logic       BUS_RST;
  logic       USER_RST;
  logic       DCM1_LOCKED;
  logic [7:0] DCM1_STATUS;
  logic       DCM2_LOCKED;
  logic [7:0] DCM2_STATUS;
  logic       DCM1_RST;
  logic       DCM2_RST;
  logic       CLK_READY;
  logic       FAIL;
  logic [2:0] STATE;
  logic [1:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  dcm_lock_sequencer #(
    .RST_CYCLES    (8),
    .STABLE_CYCLES (16),
    .LOCK_TIMEOUT  (100),
    .MAX_RETRY     (3)
  ) dut (
    .BUS_CLK     (BUS_CLK),
    .BUS_RST     (BUS_RST),
    .USER_RST    (USER_RST),
    .DCM1_LOCKED (DCM1_LOCKED),
    .DCM1_STATUS (DCM1_STATUS),
    .DCM2_LOCKED (DCM2_LOCKED),
    .DCM2_STATUS (DCM2_STATUS),
    .DCM1_RST    (DCM1_RST),
    .DCM2_RST    (DCM2_RST),
    .CLK_READY   (CLK_READY),
    .FAIL        (FAIL),
    .STATE       (STATE),
    .RETRY_CNT   (RETRY_CNT),
    .LOSS_CNT    (LOSS_CNT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Output vector for a state per the state/output table:
  // {STATE, DCM1_RST, DCM2_RST, CLK_READY, FAIL, RETRY_CNT, LOSS_CNT}
  function automatic logic [16:0] ev(input int st, input int rc, input int lc);
    logic [2:0] s;
    logic       r1, r2, rdy, fl;
    s   = 3'(st);
    r1  = (st == 0) || (st == 5);
    r2  = (st != 3) && (st != 4);
    rdy = (st == 4);
    fl  = (st == 5);
    return {s, r1, r2, rdy, fl, 2'(rc), 8'(lc)};
  endfunction

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input string tag, input int st, input int rc, input int lc);
    exp_t e;
    e.tag = tag;
    e.v   = ev(st, rc, lc);
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [16:0] obs;
    e   = exp_q.pop_front();
    obs = {STATE, DCM1_RST, DCM2_RST, CLK_READY, FAIL, RETRY_CNT, LOSS_CNT};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", e.tag, obs, e.v, cyc);
    end
  endtask

  task automatic cmp(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Tick until (STATE == s) == eq, bounded by budget; returns the cycle or -1.
  task automatic wait_until(input logic [2:0] s, input bit eq, input int budget,
                            input string tag, output int at);
    int n;
    n  = 0;
    at = -1;
    while (((STATE === s) != eq) && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert ((STATE === s) == eq) else begin
      bad++;
      $error("FAIL %s: wait expired, observed state=%0d target=%0d", tag, STATE, s);
    end
    if ((STATE === s) == eq) at = cyc;
  endtask

  initial begin
    int at, ent, ex, w1, u;

    BUS_RST     = 1'b1;
    USER_RST    = 1'b0;
    DCM1_LOCKED = 1'b0;
    DCM2_LOCKED = 1'b0;
    DCM1_STATUS = 8'h00;
    DCM2_STATUS = 8'h00;
    repeat (3) tick();
    push("reset_values", 0, 0, 0);
    check();

    // Nominal bring-up; cycle 0 is the sample point right after release.
    BUS_RST = 1'b0;
    cyc     = 0;
    wait_until(3'd1, 1'b1, 20, "rst1_wait", at);
    cmp("dcm1_rst_len", at, 8);
    push("in_wait1", 1, 0, 0);
    check();
    step_to(12);
    DCM1_LOCKED = 1'b1;
    wait_until(3'd2, 1'b1, 40, "lock1_wait", at);
    cmp("enter_rst2", at, 12 + 2 + 16);
    wait_until(3'd3, 1'b1, 20, "rst2_wait", at);
    cmp("dcm2_rst_fall", at, 30 + 8);
    push("in_wait2", 3, 0, 0);
    check();
    step_to(45);
    DCM2_LOCKED = 1'b1;
    wait_until(3'd4, 1'b1, 40, "lock2_wait", at);
    cmp("clk_ready_at", at, 45 + 2 + 16);
    push("in_run", 4, 0, 0);
    check();

    // DCM2 lock loss for 3 cycles in RUN
    step_to(65);
    DCM2_LOCKED = 1'b0;
    push("run_before_loss2", 4, 0, 0);
    step_to(67);
    check();
    push("loss2_to_rst2", 2, 0, 1);
    step_to(68);
    check();
    DCM2_LOCKED = 1'b1;
    wait_until(3'd4, 1'b1, 60, "relock2_wait", at);
    cmp("relock2_run_at", at, 68 + 8 + 16);

    // DCM1 CLKIN stopped in RUN
    step_to(94);
    DCM1_STATUS = 8'h02;
    push("run_before_stop1", 4, 0, 1);
    step_to(96);
    check();
    push("stop1_to_rst1", 0, 0, 2);
    step_to(97);
    check();
    DCM1_STATUS = 8'h00;
    wait_until(3'd4, 1'b1, 80, "restart_wait", at);
    cmp("restart_run_at", at, 97 + 8 + 16 + 8 + 16);

    // Both locks fall together: DCM1 path wins, one loss counted
    step_to(147);
    DCM1_LOCKED = 1'b0;
    DCM2_LOCKED = 1'b0;
    push("both_fall", 0, 0, 3);
    step_to(150);
    check();
    DCM1_LOCKED = 1'b1;

    // Lock bounce at stability count 10 in WAIT1
    wait_until(3'd1, 1'b1, 20, "bounce_wait1", w1);
    cmp("bounce_wait1_at", w1, 150 + 8);
    step_to(w1 + 8);
    DCM1_LOCKED = 1'b0;
    tick();
    DCM1_LOCKED = 1'b1;
    push("bounce_still_wait1", 1, 0, 3);
    step_to(w1 + 26);
    check();
    push("bounce_to_rst2", 2, 0, 3);
    step_to(w1 + 27);
    check();

    // DCM2 never locks: three retries, then FAILED
    for (int i = 0; i < 4; i++) begin
      wait_until(3'd3, 1'b1, 20, "tmo_enter", ent);
      wait_until(3'd3, 1'b0, 150, "tmo_leave", ex);
      cmp("tmo_len", ex - ent, 100);
      if (i < 3) push("retry_step", 2, i + 1, 3);
      else       push("failed", 5, 3, 3);
      check();
    end
    repeat (5) tick();
    push("failed_sticky", 5, 3, 3);
    check();

    USER_RST = 1'b1;
    tick();
    USER_RST = 1'b0;
    u = cyc;
    push("user_rst", 0, 0, 3);
    check();

    // BUS_RST while waiting in WAIT2
    wait_until(3'd3, 1'b1, 60, "mid_wait2", at);
    cmp("mid_wait2_at", at, u + 8 + 16 + 8);
    push("mid_wait2_outs", 3, 0, 3);
    check();
    BUS_RST = 1'b1;
    tick();
    push("bus_rst_mid", 0, 0, 0);
    check();
    BUS_RST = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
